// File: rtl/io_port_responder.sv
// io_port_responder
//   Device-side endpoint for one IO port. Accepts command words from a port
//   controller over a REQ/ACK handshake, executes them against a small
//   16-bit register bank, and returns register writebacks (RegResponse) and
//   one-shot event notifications (MemResponse) on the response lines.
//
// Ports
//   sys_clk, async_rst      clock and asynchronous active-high reset
//   IOREQ / IOACK           command handshake; transfer on IOREQ && IOACK
//   IOCommandEn             1 = execute the word, 0 = accept and discard
//   IOResponseRequested     request a register writeback for this command
//   IODestRegIn             destination tag echoed on a RegResponse
//   IODataIn                command word {op[31:29], addr[28:27], -, payload[15:0]}
//   IOCommandResponse       one-cycle response strobe
//   IORegResponseFlag       response is a register writeback
//   IOMemResponseFlag       response is an event notification
//   IODestRegOut            echoed tag (0 for event notifications)
//   IODataOut               response data, zero-extended 16-bit value
//   EventIn                 asynchronous external event pin
//   CtrlOut                 live value of reg0
module io_port_responder #(
  parameter int PORTBYTEWIDTH = 4,
  parameter int NUMREGS       = 4,
  parameter int SYNCSTAGES    = 2
) (
  input  logic                       sys_clk,
  input  logic                       async_rst,
  input  logic                       IOREQ,
  output logic                       IOACK,
  input  logic                       IOCommandEn,
  input  logic                       IOResponseRequested,
  input  logic [3:0]                 IODestRegIn,
  input  logic [8*PORTBYTEWIDTH-1:0] IODataIn,
  output logic                       IOCommandResponse,
  output logic                       IORegResponseFlag,
  output logic                       IOMemResponseFlag,
  output logic [3:0]                 IODestRegOut,
  output logic [8*PORTBYTEWIDTH-1:0] IODataOut,
  input  logic                       EventIn,
  output logic [15:0]                CtrlOut
);

  localparam int IOBITWIDTH = 8 * PORTBYTEWIDTH;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_SET   = 3'd3,
    OP_CLR   = 3'd4,
    OP_ARM   = 3'd5,
    OP_RSVD  = 3'd6,
    OP_CLK   = 3'd7
  } op_e;

  logic [15:0]           regs [NUMREGS];
  logic [15:0]           event_count;
  logic                  armed_q;
  logic [SYNCSTAGES-1:0] sync_q;
  logic                  prev_q;
  logic                  pending_q;
  logic [15:0]           pending_data_q;

  op_e         op;
  logic [1:0]  addr;
  logic [15:0] payload;
  logic        xfer;
  logic        exec;
  logic        reg_op;
  logic        reg_wr;
  logic        reg_trig;
  logic        arm_xfer;
  logic [15:0] new_val;
  logic        evt_rise;
  logic        mem_fire;
  logic [15:0] count_next;
  logic        unused_fields;

  logic                  resp_n;
  logic                  regf_n;
  logic                  memf_n;
  logic [3:0]            dest_n;
  logic [IOBITWIDTH-1:0] data_n;
  logic                  pend_n;
  logic [15:0]           pend_data_n;

  assign op            = op_e'(IODataIn[31:29]);
  assign addr          = IODataIn[28:27];
  assign payload       = IODataIn[15:0];
  assign unused_fields = ^IODataIn[26:16];

  assign xfer     = IOREQ & IOACK;
  assign exec     = xfer & IOCommandEn;
  assign reg_trig = reg_op & IOResponseRequested;
  assign arm_xfer = exec & (op == OP_ARM);

  // Post-op register value; a READ reports the current contents.
  always_comb begin
    new_val = regs[addr];
    reg_op  = 1'b0;
    reg_wr  = 1'b0;
    if (exec) begin
      case (op)
        OP_WRITE: begin new_val = payload;                reg_op = 1'b1; reg_wr = 1'b1; end
        OP_READ:  begin                                   reg_op = 1'b1;                end
        OP_SET:   begin new_val = regs[addr] | payload;   reg_op = 1'b1; reg_wr = 1'b1; end
        OP_CLR:   begin new_val = regs[addr] & ~payload;  reg_op = 1'b1; reg_wr = 1'b1; end
        default:  begin end
      endcase
    end
  end

  assign evt_rise   = sync_q[SYNCSTAGES-1] & ~prev_q;
  assign count_next = event_count + 16'd1;
  // armed_q is the registered flag, so an edge coinciding with the ARM
  // transfer itself is counted but not reported.
  assign mem_fire   = evt_rise & armed_q;

  // Response arbitration: a RegResponse wins; a colliding MemResponse is
  // parked in the one-deep pending slot. The slot drains the following
  // cycle, which is always free because IOACK is low during a RegResponse.
  always_comb begin
    resp_n      = 1'b0;
    regf_n      = 1'b0;
    memf_n      = 1'b0;
    dest_n      = '0;
    data_n      = '0;
    pend_n      = pending_q;
    pend_data_n = pending_data_q;
    if (reg_trig) begin
      resp_n = 1'b1;
      regf_n = 1'b1;
      dest_n = IODestRegIn;
      data_n = IOBITWIDTH'(new_val);
      if (mem_fire) begin
        pend_n      = 1'b1;
        pend_data_n = count_next;
      end
    end else if (mem_fire) begin
      resp_n = 1'b1;
      memf_n = 1'b1;
      data_n = IOBITWIDTH'(count_next);
    end else if (pending_q) begin
      resp_n = 1'b1;
      memf_n = 1'b1;
      data_n = IOBITWIDTH'(pending_data_q);
      pend_n = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) begin
      for (int unsigned i = 0; i < NUMREGS; i++) regs[i] <= '0;
      event_count       <= '0;
      armed_q           <= 1'b0;
      sync_q            <= '0;
      prev_q            <= 1'b0;
      pending_q         <= 1'b0;
      pending_data_q    <= '0;
      IOACK             <= 1'b0;
      IOCommandResponse <= 1'b0;
      IORegResponseFlag <= 1'b0;
      IOMemResponseFlag <= 1'b0;
      IODestRegOut      <= '0;
      IODataOut         <= '0;
    end else begin
      // Drop ACK for exactly the RegResponse cycle.
      IOACK <= ~reg_trig;
      if (reg_wr) regs[addr] <= new_val;

      sync_q <= {sync_q[SYNCSTAGES-2:0], EventIn};
      prev_q <= sync_q[SYNCSTAGES-1];
      if (evt_rise) event_count <= count_next;

      if (arm_xfer)      armed_q <= 1'b1;
      else if (mem_fire) armed_q <= 1'b0;

      pending_q         <= pend_n;
      pending_data_q    <= pend_data_n;
      IOCommandResponse <= resp_n;
      IORegResponseFlag <= regf_n;
      IOMemResponseFlag <= memf_n;
      IODestRegOut      <= dest_n;
      IODataOut         <= data_n;
    end
  end

  assign CtrlOut = regs[0];

endmodule

// File: tb/tb_io_port_responder.sv
module tb_io_port_responder;

  logic        sys_clk = 1'b0;
  logic        async_rst = 1'b1;
  logic        IOREQ = 1'b0;
  logic        IOACK;
  logic        IOCommandEn = 1'b0;
  logic        IOResponseRequested = 1'b0;
  logic [3:0]  IODestRegIn = '0;
  logic [31:0] IODataIn = '0;
  logic        IOCommandResponse;
  logic        IORegResponseFlag;
  logic        IOMemResponseFlag;
  logic [3:0]  IODestRegOut;
  logic [31:0] IODataOut;
  logic        EventIn = 1'b0;
  logic [15:0] CtrlOut;

  int passed = 0;
  int total  = 0;

  io_port_responder #(.PORTBYTEWIDTH(4), .NUMREGS(4), .SYNCSTAGES(2)) dut (
    .sys_clk             (sys_clk),
    .async_rst           (async_rst),
    .IOREQ               (IOREQ),
    .IOACK               (IOACK),
    .IOCommandEn         (IOCommandEn),
    .IOResponseRequested (IOResponseRequested),
    .IODestRegIn         (IODestRegIn),
    .IODataIn            (IODataIn),
    .IOCommandResponse   (IOCommandResponse),
    .IORegResponseFlag   (IORegResponseFlag),
    .IOMemResponseFlag   (IOMemResponseFlag),
    .IODestRegOut        (IODestRegOut),
    .IODataOut           (IODataOut),
    .EventIn             (EventIn),
    .CtrlOut             (CtrlOut)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive one command at a negedge; returns 1 time unit after the transfer
  // edge, i.e. inside the response cycle.
  task automatic send(input string name, input logic en, input logic rr,
                      input logic [3:0] tag, input logic [31:0] word);
    @(negedge sys_clk);
    IOREQ               = 1'b1;
    IOCommandEn         = en;
    IOResponseRequested = rr;
    IODestRegIn         = tag;
    IODataIn            = word;
    chk({name, "_ack"}, {31'd0, IOACK}, 32'd1);
    @(posedge sys_clk);
    #1;
    IOREQ               = 1'b0;
    IOCommandEn         = 1'b0;
    IOResponseRequested = 1'b0;
  endtask

  task automatic settle();
    @(posedge sys_clk);
    #1;
  endtask

  // One EventIn pulse; records every strobe seen in the following window.
  task automatic pulse(output int n, output logic [31:0] d, output logic [3:0] dst,
                       output logic mf, output logic rf);
    n = 0; d = '0; dst = '0; mf = 1'b0; rf = 1'b0;
    @(negedge sys_clk);
    EventIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (i == 2) EventIn = 1'b0;
      if (IOCommandResponse) begin
        n++;
        d   = IODataOut;
        dst = IODestRegOut;
        mf  = IOMemResponseFlag;
        rf  = IORegResponseFlag;
      end
    end
  endtask

  int          n;
  logic [31:0] d;
  logic [3:0]  dst;
  logic        mf, rf;

  initial begin
    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_ack",  {31'd0, IOACK}, 32'd0);
    chk("rst_resp", {31'd0, IOCommandResponse}, 32'd0);
    chk("rst_ctrl", {16'd0, CtrlOut}, 32'd0);
    chk("rst_data", IODataOut, 32'd0);
    async_rst = 1'b0;
    #1;
    chk("ack_before_edge", {31'd0, IOACK}, 32'd0);
    settle();
    chk("ack_after_edge", {31'd0, IOACK}, 32'd1);

    // WRITE reg2 = A5A5 with response, tag 7
    send("wr2", 1'b1, 1'b1, 4'h7, 32'h3000A5A5);
    chk("wr2_resp", {31'd0, IOCommandResponse}, 32'd1);
    chk("wr2_regf", {31'd0, IORegResponseFlag}, 32'd1);
    chk("wr2_memf", {31'd0, IOMemResponseFlag}, 32'd0);
    chk("wr2_dest", {28'd0, IODestRegOut}, 32'd7);
    chk("wr2_data", IODataOut, 32'h0000A5A5);
    chk("wr2_ack_low", {31'd0, IOACK}, 32'd0);
    settle();
    chk("wr2_ack_back", {31'd0, IOACK}, 32'd1);
    chk("wr2_strobe_end", {31'd0, IOCommandResponse}, 32'd0);
    chk("idle_data_zero", IODataOut, 32'd0);

    // Back-to-back WRITE / SET / CLR on reg0 without responses
    send("wr0", 1'b1, 1'b0, 4'h0, 32'h200000F0);
    chk("wr0_ctrl", {16'd0, CtrlOut}, 32'h00F0);
    chk("wr0_resp", {31'd0, IOCommandResponse}, 32'd0);
    send("set0", 1'b1, 1'b0, 4'h0, 32'h6000000F);
    chk("set0_ctrl", {16'd0, CtrlOut}, 32'h00FF);
    chk("set0_resp", {31'd0, IOCommandResponse}, 32'd0);
    send("clr0", 1'b1, 1'b0, 4'h0, 32'h800000F0);
    chk("clr0_ctrl", {16'd0, CtrlOut}, 32'h000F);
    chk("clr0_resp", {31'd0, IOCommandResponse}, 32'd0);

    // Discarded write, then READ reg1
    send("wr1_dis", 1'b0, 1'b1, 4'h3, 32'h28001234);
    chk("wr1_dis_resp", {31'd0, IOCommandResponse}, 32'd0);
    send("rd1", 1'b1, 1'b1, 4'h5, 32'h48000000);
    chk("rd1_resp", {31'd0, IOCommandResponse}, 32'd1);
    chk("rd1_dest", {28'd0, IODestRegOut}, 32'd5);
    chk("rd1_data", IODataOut, 32'd0);
    settle();
    send("rd2", 1'b1, 1'b1, 4'hA, 32'h50000000);
    chk("rd2_data", IODataOut, 32'h0000A5A5);
    chk("rd2_dest", {28'd0, IODestRegOut}, 32'hA);
    settle();
    // Clock-command space and NOP never respond
    send("op7", 1'b1, 1'b1, 4'h2, 32'hF8000000);
    chk("op7_resp", {31'd0, IOCommandResponse}, 32'd0);
    send("nop", 1'b1, 1'b1, 4'h2, 32'h00000000);
    chk("nop_resp", {31'd0, IOCommandResponse}, 32'd0);

    // ARM then three pulses: one report with count 1
    send("arm1", 1'b1, 1'b1, 4'h6, 32'hA0000000);
    chk("arm1_resp", {31'd0, IOCommandResponse}, 32'd0);
    pulse(n, d, dst, mf, rf);
    chk("ev1_count", n, 32'd1);
    chk("ev1_data", d, 32'd1);
    chk("ev1_dest", {28'd0, dst}, 32'd0);
    chk("ev1_memf", {31'd0, mf}, 32'd1);
    chk("ev1_regf", {31'd0, rf}, 32'd0);
    pulse(n, d, dst, mf, rf);
    chk("ev2_none", n, 32'd0);
    pulse(n, d, dst, mf, rf);
    chk("ev3_none", n, 32'd0);
    send("arm2", 1'b1, 1'b0, 4'h0, 32'hA0000000);
    pulse(n, d, dst, mf, rf);
    chk("ev4_count", n, 32'd1);
    chk("ev4_data", d, 32'd4);
    chk("ev4_memf", {31'd0, mf}, 32'd1);

    // Event edge in the same cycle as a READ transfer with response
    send("arm3", 1'b1, 1'b0, 4'h0, 32'hA0000000);
    @(negedge sys_clk);
    EventIn = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    IOREQ = 1'b1; IOCommandEn = 1'b1; IOResponseRequested = 1'b1;
    IODestRegIn = 4'h9; IODataIn = 32'h50000000;
    chk("col_ack", {31'd0, IOACK}, 32'd1);
    @(posedge sys_clk);
    #1;
    IOREQ = 1'b0; IOCommandEn = 1'b0; IOResponseRequested = 1'b0;
    chk("col_reg_resp", {31'd0, IOCommandResponse}, 32'd1);
    chk("col_reg_regf", {31'd0, IORegResponseFlag}, 32'd1);
    chk("col_reg_memf", {31'd0, IOMemResponseFlag}, 32'd0);
    chk("col_reg_dest", {28'd0, IODestRegOut}, 32'd9);
    chk("col_reg_data", IODataOut, 32'h0000A5A5);
    settle();
    EventIn = 1'b0;
    chk("col_mem_resp", {31'd0, IOCommandResponse}, 32'd1);
    chk("col_mem_memf", {31'd0, IOMemResponseFlag}, 32'd1);
    chk("col_mem_regf", {31'd0, IORegResponseFlag}, 32'd0);
    chk("col_mem_dest", {28'd0, IODestRegOut}, 32'd0);
    chk("col_mem_data", IODataOut, 32'd5);
    settle();
    chk("col_end", {31'd0, IOCommandResponse}, 32'd0);
    repeat (4) settle();

    // Counter wrap
    @(negedge sys_clk);
    force dut.event_count = 16'hFFFF;
    @(negedge sys_clk);
    release dut.event_count;
    send("arm4", 1'b1, 1'b0, 4'h0, 32'hA0000000);
    pulse(n, d, dst, mf, rf);
    chk("wrap_count", n, 32'd1);
    chk("wrap_data", d, 32'd0);
    chk("wrap_memf", {31'd0, mf}, 32'd1);

    // Reset between a READ transfer and its response cycle
    @(negedge sys_clk);
    IOREQ = 1'b1; IOCommandEn = 1'b1; IOResponseRequested = 1'b1;
    IODestRegIn = 4'h4; IODataIn = 32'h50000000;
    @(posedge sys_clk);
    #1;
    async_rst = 1'b1;
    IOREQ = 1'b0; IOCommandEn = 1'b0; IOResponseRequested = 1'b0;
    #1;
    chk("mid_rst_resp", {31'd0, IOCommandResponse}, 32'd0);
    chk("mid_rst_ack", {31'd0, IOACK}, 32'd0);
    chk("mid_rst_data", IODataOut, 32'd0);
    repeat (2) @(negedge sys_clk);
    async_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (IOCommandResponse) n++;
    end
    chk("post_rst_strobes", n, 32'd0);
    chk("post_rst_ctrl", {16'd0, CtrlOut}, 32'd0);
    send("post_rd2", 1'b1, 1'b1, 4'h1, 32'h50000000);
    chk("post_rd2_resp", {31'd0, IOCommandResponse}, 32'd1);
    chk("post_rd2_data", IODataOut, 32'd0);
    settle();
    send("post_rd1", 1'b1, 1'b1, 4'h1, 32'h48000000);
    chk("post_rd1_data", IODataOut, 32'd0);
    settle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
